// File: rtl/sine_pwm_out.sv
// rtl/sine_pwm_out.sv - split-magnitude sine sample to two-leg PWM with dead-time and error flags
module sine_pwm_out #(
    parameter int WIDTH = 9,
    parameter int DEAD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] pos_in,
    input  logic [WIDTH-1:0] neg_in,
    output logic             out_p,
    output logic             out_n,
    output logic             frame_start,
    output logic             err_conflict,
    output logic             err_overrun
);

    localparam int               FRAME  = (2 ** WIDTH) - 1;
    localparam logic [WIDTH-1:0] LAST   = WIDTH'(FRAME - 1);
    localparam logic [WIDTH-1:0] DEAD_W = WIDTH'(DEAD);

    typedef enum logic [1:0] {
        POL_NONE = 2'd0,
        POL_POS  = 2'd1,
        POL_NEG  = 2'd2
    } pol_t;

    logic             r_started;
    logic [WIDTH-1:0] r_slot;
    logic [WIDTH-1:0] r_shadow_mag;
    pol_t             r_shadow_pol;
    logic             r_pending;
    logic [WIDTH-1:0] r_duty;
    pol_t             r_pol;
    pol_t             r_pol_last;
    logic             r_blank_en;

    logic             w_load;
    logic [WIDTH-1:0] w_slot_next;
    logic [WIDTH-1:0] w_cap_mag;
    pol_t             w_cap_pol;
    logic             w_conflict;
    logic [WIDTH-1:0] w_duty_eff;
    pol_t             w_pol_eff;
    logic             w_blank_en_eff;
    logic             w_load_blank_en;
    logic             w_drive;

    // The first edge after reset, and every wrap, enters slot 0 and loads the frame.
    assign w_load      = !r_started || (r_slot == LAST);
    assign w_slot_next = w_load ? '0 : WIDTH'(r_slot + 1'b1);
    assign w_conflict  = (pos_in != '0) && (neg_in != '0);

    always_comb begin
        w_cap_mag = '0;
        w_cap_pol = POL_NONE;
        if ((pos_in != '0) && (neg_in == '0)) begin
            w_cap_mag = pos_in;
            w_cap_pol = POL_POS;
        end else if ((neg_in != '0) && (pos_in == '0)) begin
            w_cap_mag = neg_in;
            w_cap_pol = POL_NEG;
        end
    end

    // Blanking decision compares the incoming polarity with the last polarity actually driven.
    assign w_load_blank_en = (r_shadow_pol != POL_NONE) && (r_pol_last != POL_NONE)
                             && (r_shadow_pol != r_pol_last);

    always_comb begin
        w_duty_eff     = r_duty;
        w_pol_eff      = r_pol;
        w_blank_en_eff = r_blank_en;
        if (w_load) begin
            w_duty_eff     = r_shadow_mag;
            w_pol_eff      = r_shadow_pol;
            w_blank_en_eff = w_load_blank_en;
        end
    end

    assign w_drive = (w_slot_next < w_duty_eff) && !(w_blank_en_eff && (w_slot_next < DEAD_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_started    <= 1'b0;
            r_slot       <= '0;
            r_shadow_mag <= '0;
            r_shadow_pol <= POL_NONE;
            r_pending    <= 1'b0;
            r_duty       <= '0;
            r_pol        <= POL_NONE;
            r_pol_last   <= POL_NONE;
            r_blank_en   <= 1'b0;
            out_p        <= 1'b0;
            out_n        <= 1'b0;
            frame_start  <= 1'b0;
            err_conflict <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            r_started   <= 1'b1;
            r_slot      <= w_slot_next;
            frame_start <= w_load;
            out_p       <= w_drive && (w_pol_eff == POL_POS);
            out_n       <= w_drive && (w_pol_eff == POL_NEG);

            if (w_load) begin
                r_duty     <= r_shadow_mag;
                r_pol      <= r_shadow_pol;
                r_blank_en <= w_load_blank_en;
                if ((r_shadow_mag != '0) && (r_shadow_pol != POL_NONE)) begin
                    r_pol_last <= r_shadow_pol;
                end
            end

            // A strobe on the load edge refills the shadow for the next frame, so set beats clear.
            if (sample_valid) begin
                r_shadow_mag <= w_cap_mag;
                r_shadow_pol <= w_cap_pol;
                r_pending    <= 1'b1;
                if (w_conflict) begin
                    err_conflict <= 1'b1;
                end
                if (r_pending && !w_load) begin
                    err_overrun <= 1'b1;
                end
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sine_pwm_out.sv
// tb/tb_sine_pwm_out.sv - directed self-checking bench for sine_pwm_out
module tb_sine_pwm_out;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [8:0] pos_in;
    logic [8:0] neg_in;
    logic       out_p;
    logic       out_n;
    logic       frame_start;
    logic       err_conflict;
    logic       err_overrun;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int slot   = 0;

    sine_pwm_out #(.WIDTH(9), .DEAD(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .pos_in       (pos_in),
        .neg_in       (neg_in),
        .out_p        (out_p),
        .out_n        (out_n),
        .frame_start  (frame_start),
        .err_conflict (err_conflict),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        slot = (slot + 1) % 511;
    endtask

    task automatic goto_slot(input int n);
        while (slot != n) tick();
    endtask

    task automatic strobe(input int p, input int n);
        sample_valid = 1'b1;
        pos_in       = 9'(p);
        neg_in       = 9'(n);
        tick();
        sample_valid = 1'b0;
        pos_in       = '0;
        neg_in       = '0;
    endtask

    // Observes one whole frame starting at slot 0; -1 means the leg never went high.
    task automatic measure(input string tag, input int epc, input int epf, input int epl,
                           input int enc, input int enf, input int enl);
        int pc, pf, pl, nc, nf, nl, both, fsbad;
        pc = 0; pf = -1; pl = -1;
        nc = 0; nf = -1; nl = -1;
        both = 0; fsbad = 0;
        for (int i = 0; i < 511; i++) begin
            if (out_p === 1'b1) begin pc++; if (pf < 0) pf = i; pl = i; end
            if (out_n === 1'b1) begin nc++; if (nf < 0) nf = i; nl = i; end
            if (out_p === 1'b1 && out_n === 1'b1) both++;
            if (frame_start !== 1'(i == 0)) fsbad++;
            tick();
        end
        chk({tag, ".p_cnt"}, pc, epc);
        chk({tag, ".p_first"}, pf, epf);
        chk({tag, ".p_last"}, pl, epl);
        chk({tag, ".n_cnt"}, nc, enc);
        chk({tag, ".n_first"}, nf, enf);
        chk({tag, ".n_last"}, nl, enl);
        chk({tag, ".both_high"}, both, 0);
        chk({tag, ".frame_start"}, fsbad, 0);
    endtask

    initial begin
        int fs_cnt, fs_bad, out_hi;
        reset        = 1'b1;
        sample_valid = 1'b0;
        pos_in       = '0;
        neg_in       = '0;
        repeat (3) tick();
        chk("rst.out_p", int'(out_p), 0);
        chk("rst.out_n", int'(out_n), 0);
        chk("rst.frame_start", int'(frame_start), 0);
        chk("rst.err_conflict", int'(err_conflict), 0);
        chk("rst.err_overrun", int'(err_overrun), 0);

        reset = 1'b0;
        tick();
        slot = 0;
        chk("first.frame_start", int'(frame_start), 1);

        fs_cnt = 0; fs_bad = 0; out_hi = 0;
        for (int i = 0; i < 1200; i++) begin
            if (frame_start === 1'b1) fs_cnt++;
            if (frame_start !== 1'((i % 511) == 0)) fs_bad++;
            if (out_p !== 1'b0 || out_n !== 1'b0) out_hi++;
            tick();
        end
        chk("idle.fs_cnt", fs_cnt, 3);
        chk("idle.fs_pos", fs_bad, 0);
        chk("idle.out_high", out_hi, 0);
        chk("idle.err_conflict", int'(err_conflict), 0);
        chk("idle.err_overrun", int'(err_overrun), 0);

        goto_slot(5);
        strobe(100, 0);
        goto_slot(0);
        measure("pos100_f1", 100, 0, 99, 0, -1, -1);
        measure("pos100_f2", 100, 0, 99, 0, -1, -1);

        goto_slot(3);
        strobe(200, 0);
        goto_slot(0);
        measure("pos200", 200, 0, 199, 0, -1, -1);
        goto_slot(3);
        strobe(0, 50);
        goto_slot(0);
        measure("neg50_blank", 0, -1, -1, 46, 4, 49);
        measure("neg50_same", 0, -1, -1, 50, 0, 49);

        goto_slot(2);
        strobe(30, 40);
        chk("conflict.set", int'(err_conflict), 1);
        goto_slot(0);
        measure("conflict_frame", 0, -1, -1, 0, -1, -1);
        chk("conflict.held", int'(err_conflict), 1);

        chk("loadedge.pre", int'(err_overrun), 0);
        goto_slot(100);
        strobe(20, 0);
        goto_slot(510);
        strobe(40, 0);
        chk("loadedge.no_overrun", int'(err_overrun), 0);
        measure("pos20_blank", 16, 4, 19, 0, -1, -1);
        measure("pos40", 40, 0, 39, 0, -1, -1);
        chk("loadedge.still_clear", int'(err_overrun), 0);

        goto_slot(3);
        strobe(10, 0);
        goto_slot(20);
        strobe(300, 0);
        chk("overrun.set", int'(err_overrun), 1);
        goto_slot(0);
        measure("pos300_last_wins", 300, 0, 299, 0, -1, -1);

        goto_slot(3);
        strobe(511, 0);
        goto_slot(0);
        measure("pos511_full", 511, 0, 510, 0, -1, -1);
        goto_slot(3);
        strobe(0, 0);
        goto_slot(0);
        measure("zero_frame", 0, -1, -1, 0, -1, -1);
        goto_slot(3);
        strobe(0, 511);
        goto_slot(0);
        measure("neg511_blank", 0, -1, -1, 507, 4, 510);

        goto_slot(100);
        chk("midrst.pre_out_n", int'(out_n), 1);
        reset = 1'b1;
        tick();
        chk("midrst.out_p", int'(out_p), 0);
        chk("midrst.out_n", int'(out_n), 0);
        chk("midrst.frame_start", int'(frame_start), 0);
        chk("midrst.err_conflict", int'(err_conflict), 0);
        chk("midrst.err_overrun", int'(err_overrun), 0);
        reset = 1'b0;
        tick();
        slot = 0;
        chk("post_rst.frame_start", int'(frame_start), 1);
        chk("post_rst.out_n", int'(out_n), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sine_pwm_out.md
Name: sine_pwm_out

Overview:
- Consumer end of the split-magnitude sine sample interface: a strobe plus a 9-bit positive magnitude and a 9-bit negative magnitude.
- Converts each sample pair into a two-leg PWM drive (out_p / out_n) for an H-bridge or differential audio output stage.
- Samples are double-buffered and applied only on PWM frame boundaries.
- Inserts dead-time blanking on polarity reversal and flags protocol violations (both magnitudes nonzero, sample overrun).

Parameters:
- WIDTH, 9: magnitude width. Frame length FRAME = 2^WIDTH - 1 = 511 clk cycles.
- DEAD, 4: blanking slots at the start of a frame whose polarity differs from the last driven polarity. Legal range 0..FRAME-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; pos_in/neg_in are valid in that cycle
- pos_in  in  WIDTH  positive half-wave magnitude
- neg_in  in  WIDTH  negative half-wave magnitude
- out_p  out  1  positive leg PWM, registered
- out_n  out  1  negative leg PWM, registered
- frame_start  out  1  registered pulse, high in slot 0 of every frame
- err_conflict  out  1  sticky: a sample arrived with both pos_in and neg_in nonzero
- err_overrun  out  1  sticky: a second sample arrived before the pending sample was consumed

Behaviour:
- Reset (synchronous, active-high, overrides everything including sample_valid):
  - out_p=0, out_n=0, frame_start=0, err_conflict=0, err_overrun=0.
  - Slot counter 0, shadow magnitude 0, shadow polarity NONE, pending=0.
  - Active duty 0, last polarity pol_last=NONE.
- Frame timing:
  - Slot counter runs 0..FRAME-1 and wraps.
  - The first cycle after reset deasserts is slot 0: frame_start=1 there.
  - frame_start=1 exactly in slot 0, 0 otherwise; period FRAME cycles.
  - Reset asserted mid-frame aborts the frame; outputs go low on the next cycle.
- Sample capture (any cycle, reset low):
  - On sample_valid, the shadow register is written:
    - pos_in!=0, neg_in==0: magnitude=pos_in, polarity POS.
    - neg_in!=0, pos_in==0: magnitude=neg_in, polarity NEG.
    - Both zero: magnitude 0, polarity NONE.
    - Both nonzero: magnitude 0, polarity NONE, err_conflict set.
  - pending is set. If pending was already 1, err_overrun is set and the new sample overwrites (last wins).
- Frame load:
  - At the clock edge entering slot 0, the active duty and polarity are loaded from the shadow register, and pending is cleared.
  - A sample_valid sampled at that same edge writes the shadow register for the following frame; pending ends at 1 (set wins over clear) and does not count as overrun.
  - Net latency: a sample is applied at the next slot 0 strictly after its strobe edge.
- PWM generation, for slot s with active duty D and polarity P:
  - drive = (s < D) and not blank.
  - blank = (s < DEAD) when P!=NONE, pol_last!=NONE and P!=pol_last.
  - out_p = drive and P==POS; out_n = drive and P==NEG. Never both high.
  - D=0 gives no high slots. D=511 gives all 511 slots high (continuous on, except blanking).
- pol_last is updated to P at each frame load only if D!=0 and P!=NONE. Zero-magnitude frames preserve pol_last.
- Outputs are registered; out_p/out_n/frame_start for slot s all appear in the same cycle.
- Error flags clear only on reset.

Test Plan:
- Reset then idle 1200 cycles -> out_p=out_n=0 throughout; frame_start pulses exactly every 511 cycles, first in the cycle after reset deasserts; error flags 0.
- One strobe pos=100,neg=0 in frame 0 -> frame 1: out_p high slots 0..99 (100 cycles), low 100..510; out_n=0. Frame 2 repeats (no new sample).
- Frame 1 pos=200, then frame 2 neg=50 -> frame 2 out_n high slots 4..49 (46 cycles), out_p=0. A following neg=50 frame has out_n high 0..49 (no blanking).
- Strobe pos=30,neg=40 -> err_conflict=1 from the next cycle; next frame both outputs low; flag held until reset.
- Two strobes in one frame (pos=10 then pos=300) -> err_overrun=1; next frame out_p high 300 slots. A strobe at the slot-0 load edge does not set overrun.
- pos=511 -> out_p high all 511 slots of the frame. Then pos=0 frame then neg=511 -> zero frame all low; the neg frame is blanked in slots 0..3 (pol_last still POS), out_n high 507 cycles. Reset asserted mid-frame -> all outputs 0 on the next cycle.
